// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: access-mode encodings and the
// address-width helper used to size the register index.
package register_bank_pkg;

    typedef enum logic [1:0] {
        MODE_RW     = 2'b00,
        MODE_RO     = 2'b01,
        MODE_W1C    = 2'b10,
        MODE_RW_ALT = 2'b11
    } reg_mode_e;

    // A single register still needs one address bit so the port never collapses to zero width.
    function automatic int addr_width(input int n_regs);
        return (n_regs <= 2) ? 1 : $clog2(n_regs);
    endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One register of the bank. The access mode is fixed at elaboration time and
// decides how a byte-lane bus write and the hardware set pulses affect the bits.
module register_bank_cell
    import register_bank_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [1:0]        MODE      = MODE_RW,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W-1:0]   hw_set,
    output logic [DATA_W-1:0]   q
);

    localparam int SEL_W = DATA_W / 8;

    logic [DATA_W-1:0] q_next;

    // Next value: apply the masked bus write per lane, then let hardware set pulses win on W1C bits.
    always_comb begin
        q_next = q;
        if (we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (sel[b]) begin
                    case (MODE)
                        MODE_RO:  q_next[8*b +: 8] = q[8*b +: 8];
                        MODE_W1C: q_next[8*b +: 8] = q[8*b +: 8] & ~data_in[8*b +: 8];
                        default:  q_next[8*b +: 8] = data_in[8*b +: 8];
                    endcase
                end
            end
        end
        if (MODE == MODE_W1C) begin
            q_next = q_next | hw_set;
        end
    end

    // Register storage with synchronous reset to the per-register reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/register_bank_rw.sv
// Parametrised configuration/status register bank. Decodes the bus address and
// lock, fans writes out to one cell per register, and provides a registered read
// port with a valid strobe plus a one-cycle error pulse for bad or locked accesses.
module register_bank_rw
    import register_bank_pkg::*;
#(
    parameter int                       DATA_W    = 32,
    parameter int                       N_REGS    = 4,
    parameter logic [2*N_REGS-1:0]      REG_MODE  = '0,
    parameter logic [N_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wren,
    input  logic                                  rden,
    input  logic [addr_width(N_REGS)-1:0]         addr,
    input  logic [DATA_W/8-1:0]                   sel,
    input  logic [DATA_W-1:0]                     data_in,
    input  logic                                  lock,
    input  logic [N_REGS*DATA_W-1:0]              hw_set,
    output logic [DATA_W-1:0]                     data_out,
    output logic                                  rd_valid,
    output logic                                  err,
    output logic [N_REGS*DATA_W-1:0]              regs_o
);

    localparam int ADDR_W = addr_width(N_REGS);

    logic              addr_ok;
    logic              write_ok;
    logic              err_next;
    logic [DATA_W-1:0] rd_data;
    logic [N_REGS-1:0] we;

    // Address is legal only below N_REGS; writes also need the bank to be unlocked.
    always_comb begin
        addr_ok  = (32'(addr) < 32'(N_REGS));
        write_ok = wren && addr_ok && !lock;
        err_next = ((wren || rden) && !addr_ok) || (wren && lock);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_cell
            assign we[gi] = write_ok && (addr == ADDR_W'(gi));

            register_bank_cell #(
                .DATA_W    (DATA_W),
                .MODE      (REG_MODE[2*gi +: 2]),
                .RESET_VAL (RESET_VAL[gi*DATA_W +: DATA_W])
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .we      (we[gi]),
                .sel     (sel),
                .data_in (data_in),
                .hw_set  (hw_set[gi*DATA_W +: DATA_W]),
                .q       (regs_o[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Read mux over the current (pre-write) contents; an out-of-range address reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_data = regs_o[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-stage read pipeline and error pulse; data_out holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rden;
            err      <= err_next;
            if (rden) begin
                data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_register_bank_rw.sv
// Self-checking bench for register_bank_rw: three registers (RW, RO, W1C) with a
// scoreboard of per-cycle expected read/error outputs.
module tb_register_bank_rw;

    localparam int                DATA_W    = 32;
    localparam int                N_REGS    = 3;
    localparam logic [5:0]        REG_MODE  = {2'b10, 2'b01, 2'b00};
    localparam logic [95:0]       RESET_VAL = {32'h0000_0000, 32'hCAFE_0001, 32'h0000_0000};

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wren;
    logic        rden;
    logic [1:0]  addr;
    logic [3:0]  sel;
    logic [31:0] data_in;
    logic        lock;
    logic [95:0] hw_set;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        err;
    logic [95:0] regs_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    register_bank_rw #(
        .DATA_W    (DATA_W),
        .N_REGS    (N_REGS),
        .REG_MODE  (REG_MODE),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wren     (wren),
        .rden     (rden),
        .addr     (addr),
        .sel      (sel),
        .data_in  (data_in),
        .lock     (lock),
        .hw_set   (hw_set),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .err      (err),
        .regs_o   (regs_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of bus inputs and record what the read port must show after the edge.
    task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic lk, input logic ev, input logic ee,
                         input logic [31:0] ed);
        wren    = w;
        rden    = r;
        addr    = a;
        sel     = s;
        data_in = d;
        lock    = lk;
        sb.push_back('{valid: ev, err: ee, data: ed});
    endtask

    // Advance one clock and land just after the edge so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren    = 1'b0;
        rden    = 1'b0;
        addr    = 2'd0;
        sel     = 4'h0;
        data_in = 32'h0;
        lock    = 1'b0;
        hw_set  = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (regs_o !== RESET_VAL) begin
            errors++;
            $display("[TB] FAIL reset_regs: got %h want %h", regs_o, RESET_VAL);
        end
        checks++;
        if (rd_valid !== 1'b0 || err !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outs: got v=%b e=%b d=%h want 0 0 0", rd_valid, err, data_out);
        end
    endtask

    task automatic test_byte_write();
        drive(1'b1, 1'b0, 2'd0, 4'b0101, 32'h1122_3344, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err) begin
            errors++;
            $display("[TB] FAIL bw_write_flags: got v=%b e=%b want v=%b e=%b", rd_valid, err, e.valid, e.err);
        end
        checks++;
        if (regs_o[31:0] !== 32'h0022_0044) begin
            errors++;
            $display("[TB] FAIL bw_reg0: got %h want %h", regs_o[31:0], 32'h0022_0044);
        end
        drive(1'b0, 1'b1, 2'd0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0022_0044);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err || data_out !== e.data) begin
            errors++;
            $display("[TB] FAIL bw_read: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     rd_valid, err, data_out, e.valid, e.err, e.data);
        end
        idle();
        tick();
        checks++;
        if (rd_valid !== 1'b0 || data_out !== 32'h0022_0044) begin
            errors++;
            $display("[TB] FAIL bw_hold: got v=%b d=%h want v=0 d=%h", rd_valid, data_out, 32'h0022_0044);
        end
    endtask

    task automatic test_ro_w1c();
        drive(1'b1, 1'b0, 2'd1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (err !== e.err || regs_o[63:32] !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL ro_write: got err=%b reg1=%h want err=0 reg1=%h", err, regs_o[63:32], 32'hCAFE_0001);
        end
        idle();
        hw_set = {32'h8000_0001, 32'h0, 32'h0};
        tick();
        checks++;
        if (regs_o[95:64] !== 32'h8000_0001) begin
            errors++;
            $display("[TB] FAIL w1c_hwset: got %h want %h", regs_o[95:64], 32'h8000_0001);
        end
        hw_set = '0;
        drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (err !== e.err || regs_o[95:64] !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL w1c_clear: got err=%b reg2=%h want err=0 reg2=%h", err, regs_o[95:64], 32'h8000_0000);
        end
        hw_set = {32'h0000_0001, 32'h0, 32'hFFFF_0000};
        drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (regs_o[95:64] !== 32'h8000_0001) begin
            errors++;
            $display("[TB] FAIL w1c_set_wins: got %h want %h", regs_o[95:64], 32'h8000_0001);
        end
        checks++;
        if (regs_o[31:0] !== 32'h0022_0044) begin
            errors++;
            $display("[TB] FAIL rw_hwset_ignored: got %h want %h", regs_o[31:0], 32'h0022_0044);
        end
        idle();
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        drive(1'b1, 1'b1, 2'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err || data_out !== e.data) begin
            errors++;
            $display("[TB] FAIL collision_read: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     rd_valid, err, data_out, e.valid, e.err, e.data);
        end
        checks++;
        if (regs_o[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL collision_reg0: got %h want %h", regs_o[31:0], 32'hDEAD_BEEF);
        end
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd_exp[3];
        rd_exp[0] = 32'hDEAD_BEEF;
        rd_exp[1] = 32'hCAFE_0001;
        rd_exp[2] = 32'h8000_0001;
        // bad-address read, locked write, bad+locked write, locked read, idle
        drive(1'b0, 1'b1, 2'd3, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err || data_out !== e.data) begin
            errors++;
            $display("[TB] FAIL err_badaddr: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     rd_valid, err, data_out, e.valid, e.err, e.data);
        end
        drive(1'b1, 1'b0, 2'd0, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err || regs_o[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL err_lock: got v=%b e=%b reg0=%h want v=%b e=%b reg0=%h",
                     rd_valid, err, regs_o[31:0], e.valid, e.err, 32'hDEAD_BEEF);
        end
        drive(1'b1, 1'b0, 2'd3, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (err !== e.err || regs_o !== {32'h8000_0001, 32'hCAFE_0001, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL err_both: got e=%b regs=%h want e=%b", err, regs_o, e.err);
        end
        drive(1'b0, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err || data_out !== e.data) begin
            errors++;
            $display("[TB] FAIL lock_read: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     rd_valid, err, data_out, e.valid, e.err, e.data);
        end
        // back-to-back reads of every register, checked as they retire
        for (int i = 0; i < N_REGS; i++) begin
            drive(1'b0, 1'b1, 2'(i), 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, rd_exp[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (rd_valid !== e.valid || err !== e.err || data_out !== e.data) begin
                errors++;
                $display("[TB] FAIL b2b_read%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         i, rd_valid, err, data_out, e.valid, e.err, e.data);
            end
        end
        drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        checks++;
        if (rd_valid !== e.valid || err !== e.err) begin
            errors++;
            $display("[TB] FAIL err_single_pulse: got v=%b e=%b want v=%b e=%b", rd_valid, err, e.valid, e.err);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rden = 1'b1;
        addr = 2'd1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || data_out !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outs: got v=%b e=%b d=%h want 0 0 0", rd_valid, err, data_out);
        end
        checks++;
        if (regs_o !== RESET_VAL) begin
            errors++;
            $display("[TB] FAIL reset_mid_regs: got %h want %h", regs_o, RESET_VAL);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_byte_write();
        test_ro_w1c();
        test_collision();
        test_errors();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
